// File: rtl/teras_bridge_pkg.sv
// rtl/teras_bridge_pkg.sv - register map and bit positions shared by the teras Wishbone bridge
//
// Purpose: register offsets (adr[3:2]), STATUS and CTRL bit positions.
// Ports:   none (package).
package teras_bridge_pkg;

    localparam logic [1:0] REG_DATA_IN  = 2'd0;
    localparam logic [1:0] REG_DATA_OUT = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int STAT_IN_EMPTY      = 0;
    localparam int STAT_IN_FULL       = 1;
    localparam int STAT_OUT_EMPTY     = 2;
    localparam int STAT_OUT_FULL      = 3;
    localparam int STAT_OVF           = 4;
    localparam int STAT_UDF           = 5;
    localparam int STAT_IN_COUNT_LSB  = 8;
    localparam int STAT_OUT_COUNT_LSB = 16;

    localparam int CTRL_IO_EN      = 0;
    localparam int CTRL_SOFT_CLEAR = 1;

endpackage

// File: rtl/teras_sync_fifo.sv
// rtl/teras_sync_fifo.sv - first-word-fall-through synchronous FIFO with occupancy count
//
// Purpose: single-clock FWFT FIFO; head is valid whenever empty is low.
// Ports:   clk, rst_n (async active-low), clear (sync flush, wins over push/pop),
//          push/push_data, pop, head, count, full, empty.
module teras_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full/empty are pre-edge: a push into a full FIFO is dropped even with a concurrent pop.
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // Storage needs no reset: contents are unreachable until the pointers say otherwise.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/teras_wb_bridge.sv
// rtl/teras_wb_bridge.sv - Wishbone-to-stream bridge for the teras systolic core
//
// Purpose: four-register Wishbone slave (DATA_IN, DATA_OUT, STATUS, CTRL) feeding an operand
//          FIFO towards the core and draining a result FIFO from it, with sticky OVF/UDF flags
//          and an optional registered mirror of pushed results onto user IO.
// Ports:   clk, rst_n; wbs_* Wishbone slave; core_data_o/core_rts_o/core_rtr_i operand stream;
//          core_data_i/core_rts_i/core_rtr_o result stream; io_data_o/io_valid_o/io_oeb_o mirror.
module teras_wb_bridge
    import teras_bridge_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int IN_DEPTH  = 8,
    parameter int OUT_DEPTH = 8,
    parameter int IO_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic [DATA_W-1:0] core_data_o,
    output logic              core_rts_o,
    input  logic              core_rtr_i,
    input  logic [DATA_W-1:0] core_data_i,
    input  logic              core_rts_i,
    output logic              core_rtr_o,
    output logic [IO_W-1:0]   io_data_o,
    output logic              io_valid_o,
    output logic [IO_W:0]     io_oeb_o
);

    localparam int IN_CW  = $clog2(IN_DEPTH + 1);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    logic              accept;
    logic [1:0]        reg_sel;
    logic              wr_data_in;
    logic              rd_data_out;
    logic              wr_status;
    logic              wr_ctrl;
    logic              soft_clear;
    logic              core_pop;
    logic              core_push;
    logic              ovf;
    logic              udf;
    logic              io_en;
    logic [DATA_W-1:0] out_head;
    logic [IN_CW-1:0]  in_count;
    logic [OUT_CW-1:0] out_count;
    logic              in_full;
    logic              in_empty;
    logic              out_full;
    logic              out_empty;
    logic [DATA_W-1:0] status_word;
    logic [DATA_W-1:0] rd_data;
    logic              unused_bits;

    // Byte selects and the address bits outside [3:2] carry no meaning here.
    assign unused_bits = &{1'b0, wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // The !ack term makes every access exactly one accept plus one ack cycle.
    assign accept      = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign reg_sel     = wbs_adr_i[3:2];
    assign wr_data_in  = accept &  wbs_we_i & (reg_sel == REG_DATA_IN);
    assign rd_data_out = accept & ~wbs_we_i & (reg_sel == REG_DATA_OUT);
    assign wr_status   = accept &  wbs_we_i & (reg_sel == REG_STATUS);
    assign wr_ctrl     = accept &  wbs_we_i & (reg_sel == REG_CTRL);
    assign soft_clear  = wr_ctrl & wbs_dat_i[CTRL_SOFT_CLEAR];

    assign core_rts_o = ~in_empty;
    assign core_rtr_o = ~out_full;
    assign core_pop   = core_rts_o & core_rtr_i;
    assign core_push  = core_rts_i & core_rtr_o;

    teras_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (soft_clear),
        .push      (wr_data_in),
        .push_data (wbs_dat_i),
        .pop       (core_pop),
        .head      (core_data_o),
        .count     (in_count),
        .full      (in_full),
        .empty     (in_empty)
    );

    teras_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (soft_clear),
        .push      (core_push),
        .push_data (core_data_i),
        .pop       (rd_data_out),
        .head      (out_head),
        .count     (out_count),
        .full      (out_full),
        .empty     (out_empty)
    );

    always_comb begin
        status_word                                  = '0;
        status_word[STAT_IN_EMPTY]                   = in_empty;
        status_word[STAT_IN_FULL]                    = in_full;
        status_word[STAT_OUT_EMPTY]                  = out_empty;
        status_word[STAT_OUT_FULL]                   = out_full;
        status_word[STAT_OVF]                        = ovf;
        status_word[STAT_UDF]                        = udf;
        status_word[STAT_IN_COUNT_LSB +: 8]          = 8'(in_count);
        status_word[STAT_OUT_COUNT_LSB +: 8]         = 8'(out_count);
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA_OUT: if (!out_empty) rd_data = out_head;
            REG_STATUS:   rd_data = status_word;
            REG_CTRL:     rd_data[CTRL_IO_EN] = io_en;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            ovf        <= 1'b0;
            udf        <= 1'b0;
            io_en      <= 1'b0;
            io_valid_o <= 1'b0;
            io_data_o  <= '0;
        end else begin
            wbs_ack_o <= accept;
            wbs_dat_o <= (accept & ~wbs_we_i) ? rd_data : '0;
            // A new overflow/underflow beats a simultaneous W1C.
            ovf <= (wr_data_in & in_full) | (ovf & ~(wr_status & wbs_dat_i[STAT_OVF]));
            udf <= (rd_data_out & out_empty) | (udf & ~(wr_status & wbs_dat_i[STAT_UDF]));
            if (wr_ctrl) io_en <= wbs_dat_i[CTRL_IO_EN];
            // Mirror is gated by the io_en value in force before this edge.
            io_valid_o <= io_en & core_push;
            if (io_en & core_push) io_data_o <= core_data_i[IO_W-1:0];
        end
    end

    assign io_oeb_o = {(IO_W + 1){~io_en}};

endmodule

// File: tb/tb_teras_wb_bridge.sv
// tb/tb_teras_wb_bridge.sv - bench for teras_wb_bridge against a queue-based reference model
module tb_teras_wb_bridge;

    localparam int DATA_W    = 32;
    localparam int IN_DEPTH  = 8;
    localparam int OUT_DEPTH = 8;
    localparam int IO_W      = 24;
    localparam logic [1:0] R_DIN  = 2'd0;
    localparam logic [1:0] R_DOUT = 2'd1;
    localparam logic [1:0] R_STAT = 2'd2;
    localparam logic [1:0] R_CTRL = 2'd3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]        wbs_sel_i = 4'hF;
    logic [31:0]       wbs_adr_i = '0;
    logic [DATA_W-1:0] wbs_dat_i = '0;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic [DATA_W-1:0] core_data_o;
    logic              core_rts_o;
    logic              core_rtr_i = 1'b0;
    logic [DATA_W-1:0] core_data_i = '0;
    logic              core_rts_i = 1'b0;
    logic              core_rtr_o;
    logic [IO_W-1:0]   io_data_o;
    logic              io_valid_o;
    logic [IO_W:0]     io_oeb_o;

    always #5 clk = ~clk;

    teras_wb_bridge #(.DATA_W(DATA_W), .IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH), .IO_W(IO_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .core_data_o(core_data_o), .core_rts_o(core_rts_o), .core_rtr_i(core_rtr_i),
        .core_data_i(core_data_i), .core_rts_i(core_rts_i), .core_rtr_o(core_rtr_o),
        .io_data_o(io_data_o), .io_valid_o(io_valid_o), .io_oeb_o(io_oeb_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: FIFOs as queues, registers as plain variables.
    logic [31:0]     in_q[$];
    logic [31:0]     out_q[$];
    logic            m_ack, m_ovf, m_udf, m_io_en, m_io_valid;
    logic [31:0]     m_dat;
    logic [IO_W-1:0] m_io_data;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_io_en = 1'b0; m_io_valid = 1'b0;
        m_dat = '0; m_io_data = '0;
    endtask

    task automatic check_outputs();
        logic [IO_W:0] ones = '1;
        check_eq("ack", 64'(wbs_ack_o), 64'(m_ack));
        if (m_ack) check_eq("dat_o", 64'(wbs_dat_o), 64'(m_dat));
        check_eq("core_rts_o", 64'(core_rts_o), 64'(in_q.size() != 0));
        if (in_q.size() != 0) check_eq("core_data_o", 64'(core_data_o), 64'(in_q[0]));
        check_eq("core_rtr_o", 64'(core_rtr_o), 64'(out_q.size() != OUT_DEPTH));
        check_eq("io_valid_o", 64'(io_valid_o), 64'(m_io_valid));
        check_eq("io_data_o", 64'(io_data_o), 64'(m_io_data));
        check_eq("io_oeb_o", 64'(io_oeb_o), m_io_en ? 64'(0) : 64'(ones));
    endtask

    // Advance the model by one clock edge from the inputs currently driven.
    task automatic model_step();
        int ni = in_q.size();
        int no = out_q.size();
        logic acc = wbs_cyc_i & wbs_stb_i & ~m_ack;
        logic [31:0] st = '0;
        logic [31:0] rd = '0;
        logic in_push = 0, out_pop = 0, clr = 0, set_o = 0, set_u = 0, w1c_o = 0, w1c_u = 0;
        logic core_pop, core_push, new_io_en;
        st[0] = (ni == 0); st[1] = (ni == IN_DEPTH);
        st[2] = (no == 0); st[3] = (no == OUT_DEPTH);
        st[4] = m_ovf; st[5] = m_udf;
        st[15:8] = 8'(ni); st[23:16] = 8'(no);
        new_io_en = m_io_en;
        if (acc) begin
            case (wbs_adr_i[3:2])
                R_DIN:  if (wbs_we_i) begin if (ni == IN_DEPTH) set_o = 1; else in_push = 1; end
                R_DOUT: if (!wbs_we_i) begin if (no == 0) set_u = 1; else begin rd = out_q[0]; out_pop = 1; end end
                R_STAT: if (wbs_we_i) begin w1c_o = wbs_dat_i[4]; w1c_u = wbs_dat_i[5]; end else rd = st;
                default: if (wbs_we_i) begin new_io_en = wbs_dat_i[0]; clr = wbs_dat_i[1]; end
                         else rd = {31'd0, m_io_en};
            endcase
        end
        core_pop  = (ni != 0) && core_rtr_i;
        core_push = core_rts_i && (no != OUT_DEPTH);
        m_io_valid = m_io_en && core_push;
        if (m_io_valid) m_io_data = core_data_i[IO_W-1:0];
        if (core_pop) void'(in_q.pop_front());
        if (in_push) in_q.push_back(wbs_dat_i);
        if (out_pop) void'(out_q.pop_front());
        if (core_push) out_q.push_back(core_data_i);
        if (clr) begin in_q.delete(); out_q.delete(); end
        m_ovf = set_o | (m_ovf & ~w1c_o);
        m_udf = set_u | (m_udf & ~w1c_u);
        m_io_en = new_io_en;
        m_ack = acc;
        m_dat = acc ? rd : '0;
    endtask

    task automatic tick();
        check_outputs();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wb_acc(input logic we, input logic [1:0] r, input logic [31:0] d, output logic [31:0] rdata);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_dat_i = d;
        wbs_adr_i = ($urandom() & 32'hFFFF_FFF3) | {28'd0, r, 2'b00};
        tick();
        rdata = wbs_dat_o;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        tick();
    endtask

    task automatic wb_wr(input logic [1:0] r, input logic [31:0] d);
        logic [31:0] dummy;
        wb_acc(1'b1, r, d, dummy);
    endtask

    task automatic wb_rd(input logic [1:0] r, output logic [31:0] d);
        wb_acc(1'b0, r, $urandom(), d);
    endtask

    initial begin
        logic [31:0] rd;
        logic [IO_W:0] ones = '1;

        // Reset state
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        check_eq("rst_oeb", 64'(io_oeb_o), 64'(ones));
        check_eq("rst_rtr", 64'(core_rtr_o), 64'd1);
        rst_n = 1'b1;
        tick();

        // Four operands queued while the core stalls
        for (int i = 0; i < 4; i++) wb_wr(R_DIN, 32'h1111_0000 + 32'(i));
        check_eq("in_head", 64'(core_data_o), 64'h1111_0000);
        check_eq("in_rts", 64'(core_rts_o), 64'd1);
        wb_rd(R_STAT, rd);
        check_eq("in_count4", 64'(rd[15:8]), 64'd4);
        check_eq("in_empty0", 64'(rd[0]), 64'd0);

        // Overflow and W1C
        wb_wr(R_CTRL, 32'h2);
        for (int i = 0; i <= IN_DEPTH; i++) wb_wr(R_DIN, 32'h2222_0000 + 32'(i));
        wb_rd(R_STAT, rd);
        check_eq("ovf_set", 64'(rd[4]), 64'd1);
        check_eq("in_full", 64'(rd[1]), 64'd1);
        check_eq("in_count_full", 64'(rd[15:8]), 64'(IN_DEPTH));
        wb_wr(R_STAT, 32'h10);
        wb_rd(R_STAT, rd);
        check_eq("ovf_clr", 64'(rd[4]), 64'd0);
        core_rtr_i = 1'b1;
        for (int i = 0; i < IN_DEPTH; i++) begin
            check_eq("drain_in", 64'(core_data_o), 64'(32'h2222_0000 + 32'(i)));
            tick();
        end
        core_rtr_i = 1'b0;
        check_eq("in_dropped", 64'(core_rts_o), 64'd0);

        // Result readback and underflow
        core_rts_i = 1'b1;
        for (int i = 0; i < 3; i++) begin core_data_i = 32'hA5A5_0001 + 32'(i); tick(); end
        core_rts_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_rd(R_DOUT, rd);
            check_eq("readback", 64'(rd), 64'(32'hA5A5_0001 + 32'(i)));
        end
        wb_rd(R_DOUT, rd);
        check_eq("empty_read", 64'(rd), 64'd0);
        wb_rd(R_STAT, rd);
        check_eq("udf_set", 64'(rd[5]), 64'd1);
        wb_wr(R_STAT, 32'h20);

        // Back-pressure from the result FIFO
        core_rts_i = 1'b1;
        for (int i = 0; i < OUT_DEPTH + 3; i++) begin core_data_i = 32'hB000_0000 + 32'(i); tick(); end
        core_rts_i = 1'b0;
        check_eq("backpressure", 64'(core_rtr_o), 64'd0);
        for (int i = 0; i < OUT_DEPTH; i++) begin
            wb_rd(R_DOUT, rd);
            check_eq("bp_drain", 64'(rd), 64'(32'hB000_0000 + 32'(i)));
        end
        wb_rd(R_STAT, rd);
        check_eq("out_empty", 64'(rd[2]), 64'd1);

        // IO mirror
        wb_wr(R_CTRL, 32'h1);
        core_rts_i = 1'b1; core_data_i = 32'h1234_5678;
        tick();
        core_rts_i = 1'b0;
        check_eq("io_valid_hi", 64'(io_valid_o), 64'd1);
        check_eq("io_data", 64'(io_data_o), 64'h34_5678);
        check_eq("io_oeb_en", 64'(io_oeb_o), 64'd0);
        tick();
        check_eq("io_valid_lo", 64'(io_valid_o), 64'd0);
        wb_rd(R_STAT, rd);
        check_eq("out_count1", 64'(rd[23:16]), 64'd1);
        wb_rd(R_DOUT, rd);
        check_eq("io_result", 64'(rd), 64'h1234_5678);

        // Soft clear with both FIFOs occupied and OVF set
        for (int i = 0; i <= IN_DEPTH; i++) wb_wr(R_DIN, $urandom());
        core_rts_i = 1'b1;
        for (int i = 0; i < 2; i++) begin core_data_i = $urandom(); tick(); end
        core_rts_i = 1'b0;
        wb_wr(R_CTRL, 32'h3);
        wb_rd(R_STAT, rd);
        check_eq("clr_in_count", 64'(rd[15:8]), 64'd0);
        check_eq("clr_out_count", 64'(rd[23:16]), 64'd0);
        check_eq("clr_ovf_kept", 64'(rd[4]), 64'd1);
        wb_rd(R_CTRL, rd);
        check_eq("clr_ctrl", 64'(rd), 64'd1);
        wb_wr(R_STAT, 32'h10);

        // Asynchronous reset mid-stream, with an access in flight
        for (int i = 0; i < 3; i++) wb_wr(R_DIN, $urandom());
        core_rts_i = 1'b1;
        for (int i = 0; i < 2; i++) begin core_data_i = $urandom(); tick(); end
        core_rts_i = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_adr_i = '0; wbs_dat_i = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_ack", 64'(wbs_ack_o), 64'd0);
        check_eq("arst_rts", 64'(core_rts_o), 64'd0);
        check_eq("arst_rtr", 64'(core_rtr_o), 64'd1);
        check_eq("arst_oeb", 64'(io_oeb_o), 64'(ones));
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Randomized traffic on both sides
        for (int c = 0; c < 1500; c++) begin
            wbs_cyc_i  = ($urandom_range(0, 2) != 0);
            wbs_stb_i  = wbs_cyc_i & ($urandom_range(0, 3) != 0);
            wbs_we_i   = 1'($urandom_range(0, 1));
            wbs_adr_i  = $urandom();
            wbs_dat_i  = $urandom();
            if (wbs_adr_i[3:2] == R_CTRL && $urandom_range(0, 7) != 0) wbs_dat_i[1] = 1'b0;
            core_rts_i  = 1'($urandom_range(0, 1));
            core_rtr_i  = ($urandom_range(0, 2) == 0);
            core_data_i = $urandom();
            tick();
        end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; core_rts_i = 1'b0; core_rtr_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/teras_wb_bridge.md
# teras_wb_bridge

Parametrised Wishbone-to-stream bridge that succeeds the single-word teras bridge. It sits between the Caravel Wishbone slave port and the teras systolic core, buffering operands and results in FIFOs. It exposes a four-register memory map (data in, data out, status, control) and optionally mirrors the result stream onto user IO pads. Unlike its predecessor, results are read back over Wishbone, and overflow/underflow are reported in sticky status flags rather than lost silently.

## Interface
- DATA_W, 32: Wishbone and core data width.
- IN_DEPTH, 8: input (operand) FIFO depth; power of two, 2..128.
- OUT_DEPTH, 8: output (result) FIFO depth; power of two, 2..128.
- IO_W, 24: result bits mirrored to IO; must be ≤ DATA_W.
- clk  in  1  single clock; Wishbone and core run on it.
- rst_n  in  1  asynchronous active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle and write enable.
- wbs_sel_i  in  4  byte selects; ignored, all accesses are full-word.
- wbs_adr_i  in  32  address; only bits [3:2] are decoded.
- wbs_dat_i  in  DATA_W  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  DATA_W  read data, valid while ack is high.
- core_data_o  out  DATA_W  operand to core (input FIFO head).
- core_rts_o  out  1  operand valid (ready-to-send).
- core_rtr_i  in  1  core ready to receive.
- core_data_i  in  DATA_W  result from core.
- core_rts_i  in  1  result valid.
- core_rtr_o  out  1  bridge ready to receive a result.
- io_data_o  out  IO_W  mirrored result.
- io_valid_o  out  1  mirrored-result strobe.
- io_oeb_o  out  IO_W+1  pad output enables (active low).

## Operation
- **Access acceptance**
  - An access is accepted when cyc & stb & !ack.
  - ack is asserted the next cycle, for exactly one cycle.
  - Every access is acknowledged, whatever its offset.
- **Register map** (adr[3:2])
  - 0 DATA_IN
    - Write pushes wbs_dat_i into the input FIFO.
    - If the FIFO is full, the word is dropped, OVF is set and the access is still acked.
    - Read returns 0.
  - 1 DATA_OUT
    - Read pops the output FIFO head.
    - If the FIFO is empty, the read returns 0 and sets UDF.
    - Write is ignored.
  - 2 STATUS
    - Read layout: [0] in_empty, [1] in_full, [2] out_empty, [3] out_full, [4] OVF, [5] UDF, [15:8] in_count, [23:16] out_count; all other bits 0.
    - Write of 1 to bit 4 or bit 5 clears that bit (W1C).
  - 3 CTRL
    - Bit 0 io_en, read/write.
    - Bit 1 soft_clear, write-only, reads 0. It empties both FIFOs at the accept edge; sticky flags and io_en are unchanged.
- **Core input side**
  - core_rts_o = !in_empty; core_data_o = head word (first-word fall-through).
  - A pop occurs when core_rts_o & core_rtr_i.
- **Core output side**
  - core_rtr_o = !out_full.
  - A push occurs when core_rts_i & core_rtr_o.
- **IO mirror**
  - When io_en = 1, each result push also registers core_data_i[IO_W-1:0] onto io_data_o and pulses io_valid_o for one cycle.
  - The mirror does not pop the FIFO.
  - io_oeb_o is all-ones when io_en = 0 or during reset, and all-zeros otherwise.
- **Simultaneous events**
  - Full/empty decisions use pre-edge state. A push into a full FIFO is dropped even if a pop happens in the same cycle.
  - Push and pop on a non-full, non-empty FIFO in the same cycle leave count unchanged.
  - A soft_clear accepted in the same cycle as a core push or pop wins: the FIFO ends empty.
  - OVF or UDF set and W1C clear in the same cycle: set wins.

## Timing
- **Reset values:** wbs_ack_o 0, wbs_dat_o 0, core_rts_o 0, core_rtr_o 1, io_valid_o 0, io_data_o 0, io_oeb_o all-ones. Both FIFOs are empty; OVF = UDF = 0; io_en = 0.
- **Reset mid-operation:** reset asserted mid-transfer discards all FIFO contents immediately (asynchronous). An access in flight is not acked.
- **Wishbone:** ack follows acceptance by 1 cycle. Maximum throughput is one access every 2 cycles.
- **Wishbone write to core:** a word written to DATA_IN appears on core_data_o with core_rts_o = 1 at the ack cycle, i.e. 1 cycle after acceptance.
- **Core result to Wishbone:** a result pushed at edge N is visible in out_count and poppable by an access accepted at cycle N+1 or later.
- **IO mirror:** io_valid_o rises 1 cycle after the push edge.
- **Count wrap:** read and write pointers wrap modulo depth. Counts are sized $clog2(DEPTH+1) and never wrap.

## Structure
- Shared package teras_bridge_pkg holds:
  - register offsets REG_DATA_IN, REG_DATA_OUT, REG_STATUS, REG_CTRL;
  - STATUS bit positions;
  - CTRL bit positions.
- Sub-module teras_sync_fifo: first-word-fall-through FIFO parameterised by width and depth, with async active-low reset and outputs count, full and empty. It is instantiated twice.
- The bridge top holds the Wishbone decode, sticky flags, CTRL register and IO mirror register.

## Test plan
- Reset: check every output matches the reset value; write 4 words to DATA_IN with core_rtr_i = 0 → in_count = 4, core_data_o = first word, core_rts_o = 1.
- Overflow: write IN_DEPTH+1 words with core_rtr_i = 0 → last word dropped, STATUS bit 4 = 1. Write 0x10 to STATUS → bit 4 = 0.
- Result readback: core pushes 0xA5A5_0001..0003 → DATA_OUT reads return them in order. A 4th read returns 0 and sets UDF.
- Back-pressure: core pushes continuously with no Wishbone reads → core_rtr_o = 0 after OUT_DEPTH pushes; no data is lost after draining.
- IO mirror: set CTRL = 1, push 0x12_345678 → io_data_o = 0x345678 with a 1-cycle io_valid_o; io_oeb_o = 0; out_count = 1.
- Soft clear and reset: soft_clear while both FIFOs are non-empty → both counts = 0, OVF preserved. Asserting rst_n = 0 mid-stream empties both FIFOs asynchronously.
